// File: rtl/scroller_pkg.sv
// Shared types and constants for the code word scroller: 2-bit character
// codes, the run/hold state type and the reset word pattern.
package scroller_pkg;

    typedef logic [1:0] code_t;

    localparam code_t CODE_D = 2'b00;
    localparam code_t CODE_E = 2'b01;
    localparam code_t CODE_1 = 2'b10;
    localparam code_t CODE_0 = 2'b11;

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Reset word repeats "dE10" from the leftmost display of each group of four.
    function automatic code_t reset_code(input int idx);
        return code_t'(3 - (idx % 4));
    endfunction

endpackage

// File: rtl/code_word_scroller_tick_prescaler.sv
// Rotation-rate prescaler: counts 0..TICK_DIV-1 while run is high and
// flags the terminal count combinationally so the caller rotates on that edge.
module tick_prescaler #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic wrap
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        wrap       = run && (count_reg == LAST);
        count_next = count_reg;
        if (clear || wrap) begin
            count_next = '0;
        end else if (run) begin
            count_next = count_reg + ONE;
        end
        // Outside RUN the count is frozen, so a pause resumes mid-interval.
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/code_word_scroller.sv
// Rotates one 2-bit character code per display across N_DISP displays.
// Optional macro SCROLLER_LAP_COUNT_EN adds an 8-bit lap_count output.
module code_word_scroller
    import scroller_pkg::*;
#(
    parameter int N_DISP   = 4,
    parameter int TICK_DIV = 50000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        dir,
    input  logic                        step,
    input  logic                        load,
    input  logic [2*N_DISP-1:0]         codes_in,
    output logic [2*N_DISP-1:0]         codes,
    output logic [$clog2(N_DISP)-1:0]   pos,
    output logic                        tick
`ifdef SCROLLER_LAP_COUNT_EN
    ,
    output logic [7:0]                  lap_count
`endif
);

    localparam int PW = $clog2(N_DISP);
    localparam logic [PW-1:0] LAST_POS = PW'(N_DISP - 1);
    localparam logic [PW-1:0] ONE_POS  = PW'(1);

    state_t state_reg, state_next;
    logic   step_q_reg;
    logic   auto_wrap;
    logic   manual_rot;
    logic   rotate;

    logic [2*N_DISP-1:0] codes_reg, codes_next;
    logic [2*N_DISP-1:0] rot_left, rot_right, reset_word;
    logic [PW-1:0]       pos_reg, pos_next;
    logic                pos_wraps;
    logic                tick_reg;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (state_reg == RUN),
        .clear (load),
        .wrap  (auto_wrap)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_DISP; gi++) begin : g_slot
            assign rot_left[2*gi +: 2]   = codes_reg[2*((gi + N_DISP - 1) % N_DISP) +: 2];
            assign rot_right[2*gi +: 2]  = codes_reg[2*((gi + 1) % N_DISP) +: 2];
            assign reset_word[2*gi +: 2] = reset_code(gi);
        end
    endgenerate

    // Next-state and rotation decode; the step edge only counts while holding.
    always_comb begin
        state_next = enable ? RUN : HOLD;
        manual_rot = (state_reg == HOLD) && step && !step_q_reg;
        rotate     = auto_wrap || manual_rot;
    end

    always_comb begin
        codes_next = codes_reg;
        pos_next   = pos_reg;
        pos_wraps  = 1'b0;
        if (load) begin
            codes_next = codes_in;
            pos_next   = '0;
        end else if (rotate) begin
            if (dir) begin
                codes_next = rot_right;
                pos_wraps  = (pos_reg == '0);
                pos_next   = pos_wraps ? LAST_POS : pos_reg - ONE_POS;
            end else begin
                codes_next = rot_left;
                pos_wraps  = (pos_reg == LAST_POS);
                pos_next   = pos_wraps ? '0 : pos_reg + ONE_POS;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= HOLD;
            step_q_reg <= 1'b0;
            codes_reg  <= reset_word;
            pos_reg    <= '0;
            tick_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            step_q_reg <= step;
            codes_reg  <= codes_next;
            pos_reg    <= pos_next;
            tick_reg   <= rotate && !load;
        end
    end

`ifdef SCROLLER_LAP_COUNT_EN
    logic [7:0] lap_reg;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            lap_reg <= '0;
        end else if (rotate && pos_wraps) begin
            lap_reg <= lap_reg + 8'd1;
        end
    end

    assign lap_count = lap_reg;
`endif

    assign codes = codes_reg;
    assign pos   = pos_reg;
    assign tick  = tick_reg;

endmodule

// File: tb/tb_code_word_scroller.sv
// Self-checking bench for code_word_scroller (N_DISP=4, TICK_DIV=4) against a
// queue-based reference model of the scrolling rules.
module tb_code_word_scroller;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int PW = $clog2(N);
`ifdef SCROLLER_LAP_COUNT_EN
    localparam int VW = 2*N + PW + 1 + 8;
`else
    localparam int VW = 2*N + PW + 1;
`endif

    logic clk = 1'b0;
    logic reset, enable, dir, step, load;
    logic [2*N-1:0] codes_in;
    logic [2*N-1:0] codes;
    logic [PW-1:0]  pos;
    logic           tick;
`ifdef SCROLLER_LAP_COUNT_EN
    logic [7:0]     lap_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [1:0] m_codes[$];
    int m_pos, m_presc, m_lap;
    bit m_tick, m_stepq, m_run;

    always #5 clk = ~clk;

    code_word_scroller #(.N_DISP(N), .TICK_DIV(TD)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .dir      (dir),
        .step     (step),
        .load     (load),
        .codes_in (codes_in),
        .codes    (codes),
        .pos      (pos),
        .tick     (tick)
`ifdef SCROLLER_LAP_COUNT_EN
        ,
        .lap_count(lap_count)
`endif
    );

    function automatic logic [2*N-1:0] m_word();
        logic [2*N-1:0] w;
        for (int i = 0; i < N; i++) w[2*i +: 2] = m_codes[i];
        return w;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [PW-1:0] p;
        p = m_pos[PW-1:0];
`ifdef SCROLLER_LAP_COUNT_EN
        return {m_word(), p, m_tick, m_lap[7:0]};
`else
        return {m_word(), p, m_tick};
`endif
    endfunction

    function automatic logic [VW-1:0] obs_vec();
`ifdef SCROLLER_LAP_COUNT_EN
        return {codes, pos, tick, lap_count};
`else
        return {codes, pos, tick};
`endif
    endfunction

    // Apply one clock edge of the scrolling rules to the model.
    task automatic model_update();
        bit wrap, man;
        if (reset) begin
            m_codes = {};
            for (int i = 0; i < N; i++) m_codes.push_back(2'(3 - (i % 4)));
            m_pos = 0; m_presc = 0; m_lap = 0; m_tick = 0; m_stepq = 0; m_run = 0;
            return;
        end
        wrap = m_run && (m_presc == TD - 1);
        man  = !m_run && step && !m_stepq;
        if (load) begin
            m_codes = {};
            for (int i = 0; i < N; i++) m_codes.push_back(codes_in[2*i +: 2]);
            m_pos = 0; m_presc = 0; m_lap = 0; m_tick = 0;
            $display("load codes=%h", codes_in);
        end else begin
            if (m_run) m_presc = (m_presc + 1) % TD;
            if (wrap || man) begin
                if (!dir) begin
                    m_codes.push_front(m_codes.pop_back());
                    if (m_pos == N - 1) m_lap = (m_lap + 1) % 256;
                    m_pos = (m_pos + 1) % N;
                end else begin
                    m_codes.push_back(m_codes.pop_front());
                    if (m_pos == 0) m_lap = (m_lap + 1) % 256;
                    m_pos = (m_pos + N - 1) % N;
                end
                m_tick = 1;
                $display("rotate %s dir=%0d pos=%0d codes=%h", man ? "manual" : "auto", dir, m_pos, m_word());
            end else begin
                m_tick = 0;
            end
        end
        m_stepq = step;
        m_run   = enable;
    endtask

    task automatic do_cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1; enable = 0; dir = 0; step = 0; load = 0; codes_in = '0;
        do_cycle(); do_cycle();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL reset_model got=%h exp=%h", obs_vec(), exp_vec());
        end
        checks++;
        if (codes !== 8'b00_01_10_11 || pos !== '0 || tick !== 1'b0) begin
            failures++; $display("FAIL reset_pattern got codes=%h pos=%0d tick=%0b exp codes=1b pos=0 tick=0", codes, pos, tick);
        end
        reset = 0;
    endtask

    task automatic test_auto(input bit d, input int ncyc);
        enable = 1; dir = d;
        for (int c = 0; c < ncyc; c++) begin
            do_cycle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL auto_dir%0d cyc=%0d got=%h exp=%h", d, c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_manual_step();
        enable = 0; dir = 0; step = 0;
        do_cycle();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 8; c++) begin
                step = (c < 5);
                do_cycle();
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++; $display("FAIL manual_step r=%0d c=%0d got=%h exp=%h", r, c, obs_vec(), exp_vec());
                end
            end
        end
        checks++;
        if (pos !== 2'd2 || codes !== 8'b10_11_00_01) begin
            failures++; $display("FAIL manual_two_steps got pos=%0d codes=%h exp pos=2 codes=b1", pos, codes);
        end
        // Step edges while running must not add rotations.
        enable = 1;
        for (int c = 0; c < 14; c++) begin
            step = c[1];
            do_cycle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL step_in_run c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
        end
        step = 0;
    endtask

    task automatic test_prescaler_hold();
        enable = 0; load = 1; codes_in = 8'h1b;
        do_cycle();
        load = 0;
        enable = 1; do_cycle(); do_cycle(); do_cycle();
        enable = 0;
        for (int c = 0; c < 10; c++) do_cycle();
        enable = 1;
        for (int c = 0; c < 8; c++) begin
            do_cycle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL presc_hold c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_load_on_wrap();
        int guard = 0;
        enable = 1; dir = 0;
        while (!(m_run && m_presc == TD - 1) && guard < 20) begin
            do_cycle(); guard++;
        end
        checks++;
        if (guard >= 20) begin
            failures++; $display("FAIL load_wrap_wait got=timeout exp=terminal_count");
        end
        load = 1; codes_in = 8'b11_11_00_01;
        do_cycle();
        load = 0;
        checks++;
        if (codes !== 8'b11_11_00_01 || pos !== '0 || tick !== 1'b0) begin
            failures++; $display("FAIL load_on_wrap got codes=%h pos=%0d tick=%0b exp codes=f1 pos=0 tick=0", codes, pos, tick);
        end
        for (int c = 0; c < 6; c++) begin
            do_cycle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL after_load c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_interval();
        reset = 1; do_cycle(); reset = 0;
        enable = 1; dir = 0;
        for (int c = 0; c < 34; c++) do_cycle();
        do_cycle(); do_cycle();
        reset = 1;
        do_cycle();
        checks++;
        if (obs_vec() !== exp_vec() || codes !== 8'h1b || tick !== 1'b0) begin
            failures++; $display("FAIL reset_mid got=%h exp=%h", obs_vec(), exp_vec());
        end
        reset = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset    = ($urandom_range(0, 79) == 0);
            load     = ($urandom_range(0, 24) == 0);
            enable   = ($urandom_range(0, 9) < 6);
            dir      = ($urandom_range(0, 7) == 0) ? ~dir : dir;
            step     = $urandom_range(0, 1);
            codes_in = 8'($urandom);
            do_cycle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL random c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
        end
        reset = 0; load = 0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_auto(1'b0, 14);
        test_reset();
        test_auto(1'b1, 10);
        test_reset();
        test_manual_step();
        test_prescaler_hold();
        test_load_on_wrap();
        test_reset_mid_interval();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
